// File: rtl/crossbar_egress_port.sv
// crossbar_egress_port: one crossbar output channel; locks onto the arbiter's
// granted input for a whole frame and forwards its beats through one
// registered valid/ready stage, truncating frames longer than MAX_BEATS.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   grant_i              one-hot grant from the arbiter (sampled only in IDLE)
//   in_data_i/valid/last per-input beat streams, input k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_ready_o           per-input ready, only the locked input can be high
//   out_data/valid/last  registered egress beat, out_ready_i is egress ready
//   busy_o               high whenever a frame is in progress
//   release_o            one-cycle pulse when a frame has fully left
//   grant_err_o          one-cycle pulse on a multi-hot grant in IDLE
//   oversize_o           one-cycle pulse when a frame is truncated
//   frame_count_o        completed frames, wrapping
module crossbar_egress_port #(
    parameter int NUM_INPUTS = 3,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 1522
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_INPUTS-1:0]            grant_i,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data_i,
    input  logic [NUM_INPUTS-1:0]            in_valid_i,
    input  logic [NUM_INPUTS-1:0]            in_last_i,
    output logic [NUM_INPUTS-1:0]            in_ready_o,
    output logic [DATA_WIDTH-1:0]            out_data_o,
    output logic                             out_valid_o,
    output logic                             out_last_o,
    input  logic                             out_ready_i,
    output logic                             busy_o,
    output logic                             release_o,
    output logic                             grant_err_o,
    output logic                             oversize_o,
    output logic [15:0]                      frame_count_o
);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam int SW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic [1:0] {IDLE, FWD, DRAIN, DISCARD} state_t;

    state_t                  state;
    logic [SW-1:0]           sel;
    logic [SW-1:0]           grant_idx;
    logic [CW-1:0]           beats;
    logic [NUM_INPUTS-1:0]   sel_hot;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_valid;
    logic                    sel_last;
    logic                    grant_any;
    logic                    grant_one;
    logic                    take;
    logic                    accept;
    logic                    out_fire;
    logic                    at_limit;

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < NUM_INPUTS; k++)
            if (grant_i[k]) grant_idx = SW'(k);
    end

    assign grant_any = |grant_i;
    assign grant_one = grant_any && ((grant_i & (grant_i - NUM_INPUTS'(1))) == '0);
    assign sel_hot   = NUM_INPUTS'(1) << sel;
    assign sel_data  = in_data_i[int'(sel) * DATA_WIDTH +: DATA_WIDTH];
    assign sel_valid = in_valid_i[sel];
    assign sel_last  = in_last_i[sel];
    assign out_fire  = out_valid_o && out_ready_i;
    // FWD may only refill the output register when it is empty or emptying;
    // DISCARD swallows beats regardless of the output side.
    assign take       = (state == DISCARD) || (state == FWD && (!out_valid_o || out_ready_i));
    assign in_ready_o = take ? sel_hot : '0;
    assign accept     = sel_valid && take;
    // the beat being accepted now is beat number MAX_BEATS
    assign at_limit   = beats == CW'(MAX_BEATS - 1);
    assign busy_o     = state != IDLE;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            sel           <= '0;
            beats         <= '0;
            out_data_o    <= '0;
            out_valid_o   <= 1'b0;
            out_last_o    <= 1'b0;
            release_o     <= 1'b0;
            grant_err_o   <= 1'b0;
            oversize_o    <= 1'b0;
            frame_count_o <= '0;
        end else begin
            release_o   <= 1'b0;
            grant_err_o <= 1'b0;
            oversize_o  <= 1'b0;
            if (out_fire) out_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_one) begin
                        sel   <= grant_idx;
                        state <= FWD;
                    end else begin
                        grant_err_o <= grant_any;
                    end
                end
                FWD: begin
                    if (accept) begin
                        out_data_o  <= sel_data;
                        out_valid_o <= 1'b1;
                        out_last_o  <= sel_last || at_limit;
                        oversize_o  <= !sel_last && at_limit;
                        beats       <= beats + CW'(1);
                        state       <= sel_last ? DRAIN : at_limit ? DISCARD : FWD;
                    end
                end
                DISCARD: begin
                    if (accept && sel_last) state <= DRAIN;
                end
                DRAIN: begin
                    // completes once the final held beat (if any) has left
                    if (!out_valid_o || out_ready_i) begin
                        release_o     <= 1'b1;
                        frame_count_o <= frame_count_o + 16'd1;
                        beats         <= '0;
                        state         <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/crossbar_egress_port.md
Name: crossbar_egress_port

Overview:
- One egress channel of the crossbar, directly downstream of the round-robin arbiter; one instance per output port.
- Takes the arbiter's one-hot grant and locks onto the granted input for a whole frame.
- Forwards that input's beat stream through one registered valid/ready stage.
- Pulses release_o back to the arbiter when the frame has fully left, so the arbiter can re-arbitrate.

Parameters:
- NUM_INPUTS, 3, number of crossbar inputs; equals the arbiter width.
- DATA_WIDTH, 8, bits per beat.
- MAX_BEATS, 1522, frame length limit in beats; counter width is clog2(MAX_BEATS+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- grant_i  in  NUM_INPUTS  one-hot grant from the arbiter; all zero means no grant.
- in_data_i  in  NUM_INPUTS*DATA_WIDTH  input beats; input k occupies slice [k*DATA_WIDTH +: DATA_WIDTH].
- in_valid_i  in  NUM_INPUTS  per-input valid.
- in_last_i  in  NUM_INPUTS  per-input end-of-frame marker.
- in_ready_o  out  NUM_INPUTS  per-input ready; only the locked input's bit can be high.
- out_data_o  out  DATA_WIDTH  egress beat.
- out_valid_o  out  1  egress valid.
- out_last_o  out  1  egress end-of-frame marker.
- out_ready_i  in  1  egress ready.
- busy_o  out  1  high in every state except IDLE.
- release_o  out  1  one-cycle pulse when a frame is complete.
- grant_err_o  out  1  one-cycle pulse when the grant is not one-hot.
- oversize_o  out  1  one-cycle pulse when a frame is truncated.
- frame_count_o  out  16  count of completed frames; wraps.

Behaviour:
- Reset values: all outputs 0, out_data_o 0; state IDLE; sel 0; beat counter 0. Reset takes effect mid-frame: any held beat is dropped and no release_o is issued.
- States: IDLE, FWD, DRAIN, DISCARD.
- IDLE:
  - Exactly one grant_i bit set: latch its index into sel, go to FWD next cycle. The grant is sampled only in IDLE.
  - More than one bit set: pulse grant_err_o, stay in IDLE.
  - All zero: stay in IDLE.
- FWD:
  - in_ready_o[sel] = !out_valid_o || out_ready_i; all other in_ready_o bits are 0.
  - Accept = in_valid_i[sel] && in_ready_o[sel].
  - On accept: out_data_o, out_last_o and out_valid_o load next cycle, so latency is 1 cycle. The beat counter increments.
  - Output accepted with no new input accepted: out_valid_o clears.
  - Sustains 1 beat per cycle when out_ready_i is held high.
  - grant_i changes are ignored while not in IDLE.
- End of frame: accept with in_last_i[sel]=1 -> DRAIN. in_ready_o is all zero while in DRAIN.
- Oversize:
  - Trigger: an accepted beat is beat number MAX_BEATS and in_last_i is 0.
  - That beat goes out with out_last_o forced to 1; oversize_o pulses.
  - Next state is DISCARD.
- DISCARD:
  - in_ready_o[sel] = 1; input beats are consumed and not forwarded.
  - In parallel, the held output beat drains normally.
  - On in_last_i[sel] accepted -> DRAIN.
  - If the truncated beat has not yet left, DRAIN completes when it does.
- DRAIN: when out_valid_o && out_ready_i, or if the output register is already empty:
  - pulse release_o;
  - frame_count_o increments, wrapping 16'hFFFF -> 0;
  - counter clears, state -> IDLE.
- Re-grant timing: the arbiter may re-grant in the cycle release_o is high. IDLE samples grant_i on the following cycle, so the minimum inter-frame gap at the output is 2 cycles.
- Stalls: out_data_o and out_last_o must not change while out_valid_o=1 and out_ready_i=0.
- Boundary beat: a 1-beat frame (in_last_i on the first beat) is legal. A frame of exactly MAX_BEATS beats whose last beat has in_last_i=1 is not oversize.

Test Plan:
- Reset: hold rst_i for 2 cycles -> all outputs 0. Then grant_i=3'b010 and input 1 sends 4 beats 0xA0..0xA3 with last on 0xA3, out_ready_i=1 -> out_data_o is A0..A3 on consecutive cycles starting 1 cycle after the first accept; out_last_o on A3; release_o pulses once; frame_count_o=1.
- Backpressure: out_ready_i toggles 1,0,0,1 during a 3-beat frame on input 0 -> no beat lost or duplicated; out_data_o stable while stalled; in_ready_o[0] low whenever out_valid_o=1 and out_ready_i=0.
- Grant error and lockout:
  - grant_i=3'b101 in IDLE -> grant_err_o pulses, busy_o stays 0.
  - Locked on input 2, grant_i switched to 3'b001 mid-frame -> still forwards input 2 only; in_ready_o = 3'b100 or 3'b000.
- Oversize: MAX_BEATS=4, 7-beat frame on input 0 -> 4 beats out with last on beat 4; oversize_o pulses; input beats 5-7 consumed and not forwarded; then release_o.
- Mid-frame reset: rst_i asserted after beat 2 of a 5-beat frame -> next cycle all outputs 0, state IDLE, frame_count_o unchanged at 0.
- Back-to-back: regrant is given in the release_o cycle -> next frame's first beat appears at the output 2 cycles after the previous out_last_o handshake.
- Wrap: preset via 65535 frames, or force in sim -> frame_count_o wraps 16'hFFFF -> 0.
